state_sequence_checker: RTL and testbench

STATE_SEQUENCE_CHECKER -- requirements
Module: state_sequence_checker

---
 rtl/state_sequence_checker_if.sv | 34 +++
 rtl/state_sequence_checker.sv | 123 ++++++++++++
 tb/tb_state_sequence_checker.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_sequence_checker_if.sv
// Bus between the sequence checker and its environment: observed state in, status/counters out.
// Macro STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN adds the cycle_count signal.
interface state_sequence_checker_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       state;
   logic             clear_err;
   logic [3:0]       decoded;
   logic             locked;
   logic             seq_error;
   logic             err_sticky;
   logic [CNT_W-1:0] err_count;
`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output state, clear_err,
      input  decoded, locked, seq_error, err_sticky, err_count, cycle_count
   );
   modport slave (
      input  state, clear_err,
      output decoded, locked, seq_error, err_sticky, err_count, cycle_count
   );
`else
   modport master (
      output state, clear_err,
      input  decoded, locked, seq_error, err_sticky, err_count
   );
   modport slave (
      input  state, clear_err,
      output decoded, locked, seq_error, err_sticky, err_count
   );
`endif
endinterface

// File: rtl/state_sequence_checker.sv
// Checks that a 2-bit state walks a->b->c->d->a, locks after LOCK_COUNT good steps, flags slips.
// Macro STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN enables the d->a wrap counter (cycle_count).
module state_sequence_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   state_sequence_checker_if.slave bus
);
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } fsm_t;

   localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   fsm_t             fsm_q, fsm_d;
   logic [1:0]       s_q, s_d;
   logic             have_q, have_d;
   logic [3:0]       run_q, run_d;
   logic             seq_error_q, seq_error_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [1:0]       s_inc;
   logic             correct;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q        <= HUNT;
         s_q          <= 2'd0;
         have_q       <= 1'b0;
         run_q        <= 4'd0;
         seq_error_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         fsm_q        <= fsm_d;
         s_q          <= s_d;
         have_q       <= have_d;
         run_q        <= run_d;
         seq_error_q  <= seq_error_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
      end
   end

   always_comb begin
      s_inc        = s_q + 2'd1;
      correct      = have_q && (bus.state == s_inc);
      fsm_d        = fsm_q;
      run_d        = run_q;
      seq_error_d  = 1'b0;
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      s_d          = bus.state;
      have_d       = 1'b1;

      if (bus.clear_err) begin
         err_sticky_d = 1'b0;
         err_count_d  = '0;
      end

      case (fsm_q)
         HUNT: begin
            // Misses while hunting only restart the run; they are not reportable errors.
            if (!correct) begin
               run_d = 4'd0;
            end else if (run_q == LOCK_LAST) begin
               fsm_d = LOCKED;
               run_d = 4'd0;
            end else begin
               run_d = run_q + 4'd1;
            end
         end
         LOCKED: begin
            if (!correct) begin
               seq_error_d  = 1'b1;
               err_sticky_d = 1'b1;
               // A violation wins over a simultaneous clear and counts as the first new error.
               if (bus.clear_err)
                  err_count_d = CNT_ONE;
               else if (err_count_q != CNT_MAX)
                  err_count_d = err_count_q + CNT_ONE;
               fsm_d = HUNT;
               run_d = 4'd0;
            end
         end
         default: begin
            fsm_d = HUNT;
            run_d = 4'd0;
         end
      endcase
   end

   assign bus.locked     = (fsm_q == LOCKED);
   assign bus.seq_error  = seq_error_q;
   assign bus.err_sticky = err_sticky_q;
   assign bus.err_count  = err_count_q;
   assign bus.decoded    = have_q ? (4'b0001 << s_q) : 4'b0000;

`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cycle_count_q <= '0;
      else
         cycle_count_q <= cycle_count_d;
   end

   // fsm_d covers both staying locked and the edge that enters LOCKED.
   always_comb begin
      cycle_count_d = cycle_count_q;
      if (correct && (s_q == 2'd3) && (fsm_d == LOCKED))
         cycle_count_d = cycle_count_q + CNT_ONE;
   end

   assign bus.cycle_count = cycle_count_q;
`endif
endmodule

// File: tb/tb_state_sequence_checker.sv
// Scoreboard bench for state_sequence_checker (LOCK_COUNT=4, CNT_W=8).
module tb_state_sequence_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   state_sequence_checker_if #(.CNT_W(8)) bus();

   state_sequence_checker #(.LOCK_COUNT(4), .CNT_W(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [3:0] dec;
      logic       lk;
      logic       se;
      logic       st;
      logic [7:0] ec;
      logic [7:0] cc;
   } obs_t;

   obs_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   bit       m_have;
   int       m_s;
   int       m_run;
   bit       m_locked;
   bit       m_err;
   bit       m_sticky;
   int       m_cnt;
   int       m_cyc;

   task automatic model_reset();
      m_have = 0; m_s = 0; m_run = 0; m_locked = 0;
      m_err = 0; m_sticky = 0; m_cnt = 0; m_cyc = 0;
      sb_q.delete();
   endtask

   task automatic model_edge(input int v, input bit clr);
      bit good;
      bit was_locked;
      good       = m_have && (v == ((m_s + 1) % 4));
      was_locked = m_locked;
      m_err      = 0;
      if (was_locked && !good) begin
         m_err    = 1;
         m_sticky = 1;
         m_cnt    = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         m_locked = 0;
         m_run    = 0;
      end else if (clr) begin
         m_sticky = 0;
         m_cnt    = 0;
      end
      if (!was_locked) begin
         if (good) begin
            m_run = m_run + 1;
            if (m_run == 4) begin
               m_locked = 1;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
         end
      end
`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
      if (good && m_s == 3 && v == 0 && m_locked)
         m_cyc = (m_cyc + 1) % 256;
`endif
      m_s    = v;
      m_have = 1;
   endtask

   function automatic obs_t model_out();
      obs_t e;
      e.dec = m_have ? (4'b0001 << m_s) : 4'b0000;
      e.lk  = m_locked;
      e.se  = m_err;
      e.st  = m_sticky;
      e.ec  = 8'(m_cnt);
      e.cc  = 8'(m_cyc);
      return e;
   endfunction

   function automatic obs_t dut_out();
      obs_t g;
      g.dec = bus.decoded;
      g.lk  = bus.locked;
      g.se  = bus.seq_error;
      g.st  = bus.err_sticky;
      g.ec  = bus.err_count;
`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
      g.cc  = bus.cycle_count;
`else
      g.cc  = 8'd0;
`endif
      return g;
   endfunction

   // Drive one sample, queue the expected result, and advance past the edge.
   task automatic step(input int v, input bit clr);
      bus.state     = 2'(v);
      bus.clear_err = clr;
      model_edge(v, clr);
      sb_q.push_back(model_out());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t g, e;
      rst = 1'b1;
      bus.state = 2'd0;
      bus.clear_err = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      g = dut_out(); e = model_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", g, e);
      end
      #2 rst = 1'b0;
      #1;
      g = dut_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_release got=%h exp=%h", g, e);
      end
      $display("test_reset: done");
   endtask

   task automatic test_lock();
      obs_t g, e;
      int seq[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      for (int i = 0; i < 9; i++) begin
         step(seq[i], 1'b0);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL lock i=%0d got=%h exp=%h", i, g, e);
         end
         $display("lock i=%0d v=%0d dec=%b locked=%b", i, seq[i], g.dec, g.lk);
      end
      total++;
      if (bus.locked !== 1'b1) begin
         bad++; $display("FAIL lock_reached got=%b exp=1", bus.locked);
      end
   endtask

   task automatic test_violation();
      obs_t g, e;
      int seq[7] = '{1, 3, 0, 1, 2, 3, 0};
      for (int i = 0; i < 7; i++) begin
         step(seq[i], 1'b0);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL violation i=%0d got=%h exp=%h", i, g, e);
         end
         $display("violation i=%0d v=%0d se=%b ec=%0d locked=%b", i, seq[i], g.se, g.ec, g.lk);
      end
   endtask

   task automatic test_saturation();
      obs_t g, e;
      int   n;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 5; k++) begin
            n = (k < 4) ? (m_s + 1) % 4 : m_s;
            step(n, 1'b0);
            e = sb_q.pop_front(); g = dut_out(); total++;
            if (g !== e) begin
               bad++; $display("FAIL saturation c=%0d k=%0d got=%h exp=%h", c, k, g, e);
            end
         end
      end
      total++;
      if (bus.err_count !== 8'd255 || bus.err_sticky !== 1'b1) begin
         bad++; $display("FAIL saturation_cap got=%0d/%b exp=255/1", bus.err_count, bus.err_sticky);
      end
      $display("saturation: err_count=%0d sticky=%b", bus.err_count, bus.err_sticky);
      step((m_s + 1) % 4, 1'b1);
      e = sb_q.pop_front(); g = dut_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL clear got=%h exp=%h", g, e);
      end
      $display("clear: err_count=%0d sticky=%b", g.ec, g.st);
   endtask

   task automatic test_clear_on_violation();
      obs_t g, e;
      int   n;
      bit   clr;
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 5; k++) begin
            n   = (k < 4) ? (m_s + 1) % 4 : (m_s + 2) % 4;
            clr = (c == 7) && (k == 4);
            step(n, clr);
            e = sb_q.pop_front(); g = dut_out(); total++;
            if (g !== e) begin
               bad++; $display("FAIL clear_on_viol c=%0d k=%0d got=%h exp=%h", c, k, g, e);
            end
         end
      end
      total++;
      if (bus.err_count !== 8'd1 || bus.err_sticky !== 1'b1) begin
         bad++; $display("FAIL clear_on_viol_final got=%0d/%b exp=1/1", bus.err_count, bus.err_sticky);
      end
      $display("clear_on_violation: err_count=%0d sticky=%b", bus.err_count, bus.err_sticky);
   endtask

   task automatic test_async_reset();
      obs_t g, e;
      int   n;
      for (int k = 0; k < 5; k++) begin
         step((m_s + 1) % 4, 1'b0);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, g, e);
         end
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      e = model_out(); g = dut_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL async_reset got=%h exp=%h", g, e);
      end
      repeat (2) @(posedge clk);
      #1;
      g = dut_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_hold got=%h exp=%h", g, e);
      end
      #2 rst = 1'b0;
      #1;
      g = dut_out(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_deassert got=%h exp=%h", g, e);
      end
      for (int k = 0; k < 7; k++) begin
         n = (k < 2) ? 0 : (m_s + 1) % 4;
         step(n, 1'b0);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL relock k=%0d got=%h exp=%h", k, g, e);
         end
         $display("relock k=%0d v=%0d se=%b locked=%b", k, n, g.se, g.lk);
      end
   endtask

`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
   task automatic test_cycle_count();
      obs_t g, e;
      int   start;
      start = m_cyc;
      for (int k = 0; k < 1024; k++) begin
         step((m_s + 1) % 4, 1'b0);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL cycle_count k=%0d got=%h exp=%h", k, g, e);
         end
      end
      total++;
      if (bus.cycle_count !== 8'(start)) begin
         bad++; $display("FAIL cycle_wrap got=%0d exp=%0d", bus.cycle_count, start);
      end
      $display("cycle_count: after 256 cycles value=%0d", bus.cycle_count);
   endtask
`endif

   task automatic test_back_to_back();
      obs_t g, e;
      int   n;
      bit   clr;
      for (int k = 0; k < 400; k++) begin
         n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (m_s + 1) % 4;
         clr = ($urandom_range(0, 15) == 0);
         step(n, clr);
         e = sb_q.pop_front(); g = dut_out(); total++;
         if (g !== e) begin
            bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, g, e);
         end
      end
      $display("back_to_back: 400 steps");
   endtask

   initial begin
      test_reset();
      test_lock();
      test_violation();
      test_saturation();
      test_clear_on_violation();
      test_async_reset();
`ifdef STATE_SEQUENCE_CHECKER_CYCLE_COUNT_EN
      test_cycle_count();
`endif
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
